vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares the single-port VRAM between CPU bus writes and VGA display reads.
//  CPU writes (GPIOvga_we strobes from MIO_BUS) go into a small write FIFO.
//  Display reads, from the font/graph address generators, get priority.
//  Queued writes drain in idle/blanking cycles; a starvation guard steals cycles during long active video.
//  Sits between MIO_BUS / vga address logic and the VRAM block; replaces the static we-based address mux.
// PARAMETERS
//  ADDR_W       16  VRAM address width
//  DATA_W       8   VRAM data width
//  FIFO_DEPTH   4   write FIFO entries; power of 2, >=2
//  STARVE_LIMIT 64  consecutive denied cycles with FIFO non-empty before a write cycle is stolen
// PORTS
//  clk         in   1       system clock; single clock domain
//  rst         in   1       asynchronous, active-high reset
//  cpu_we      in   1       write request; accepted only when cpu_we & cpu_ready
//  cpu_addr    in   ADDR_W  write address
//  cpu_data    in   DATA_W  write data
//  cpu_ready   out  1       FIFO not full
//  wr_pending  out  log2(FIFO_DEPTH)+1  FIFO occupancy
//  disp_req    in   1       display needs a read this cycle
//  disp_addr   in   ADDR_W  display read address
//  disp_valid  out  1       disp_data holds the read issued on the previous cycle
//  disp_data   out  DATA_W  read data; holds last value when disp_valid=0
//  vram_addr   out  ADDR_W  VRAM address, combinational from the current grant
//  vram_we     out  1       VRAM write enable, combinational
//  vram_din    out  DATA_W  VRAM write data, combinational
//  vram_dout   in   DATA_W  VRAM read data; 1-cycle synchronous read latency
//  steal_cnt   out  16      saturating count of stolen display cycles (debug)
// BEHAVIOUR
//  Reset: FIFO empty, cpu_ready=1, wr_pending=0, disp_valid=0, disp_data=0,
//   starve counter=0, steal_cnt=0.
//   vram_we=0 and vram_addr/vram_din=0 while rst=1.
//  Grant each cycle, in priority order:
//   1. STEAL: FIFO non-empty and starve counter==STARVE_LIMIT -> pop one write; counter clears.
//   2. DISP: disp_req=1 -> vram_addr=disp_addr, vram_we=0.
//   3. WRITE: FIFO non-empty -> pop head; vram_addr/din=head, vram_we=1.
//   4. IDLE: vram_we=0, vram_addr=disp_addr.
//  Starve counter: +1 on each DISP-granted cycle with FIFO non-empty; clears on any pop or when the FIFO is empty.
//  STEAL with disp_req=1 increments steal_cnt (saturates at 16'hFFFF).
//  Read latency: DISP grant in cycle N gives disp_valid=1 in N+1, with disp_data=vram_dout registered at the end of N+1.
//   Any other grant gives disp_valid=0 in N+1 and disp_data holds its value.
//  FIFO:
//   - push when cpu_we & cpu_ready.
//   - cpu_ready = !full, evaluated before any same-cycle pop: a push is rejected when full, even if a pop occurs that cycle.
//   - Push and pop in the same cycle on a non-empty FIFO leave occupancy unchanged.
//   - A push into an empty FIFO is not poppable until the next cycle: no write-through bypass.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - Writes reach VRAM in push order.
//  Coherency: a display read of an address still in the FIFO returns the old contents. This is acceptable: the next frame shows the new value.
//  Rejected cpu_we (full) is dropped silently; software polls cpu_ready via the bus status path.
//  Reset mid-operation clears the FIFO contents (queued writes are lost) and the in-flight read; disp_valid=0 in the first cycle after reset.
// STRUCTURE
//  Shared header vram_arb_defs.vh: grant encodings GNT_IDLE=2'd0, GNT_DISP=2'd1, GNT_WRITE=2'd2, GNT_STEAL=2'd3; default widths.
//  Sub-module vram_wr_fifo (DEPTH, ADDR_W+DATA_W wide; push/pop/full/empty/count).
//  Top level: grant logic, starve counter, read-valid pipeline register, steal_cnt.
// TESTING
//  1. Idle writes: disp_req=0; write (16'h0010,8'hA5) -> vram_we=1, addr 16'h0010, din A5 the cycle after the push; wr_pending back to 0.
//  2. Display read: disp_req=1, disp_addr=16'h0123, RAM holds 8'h3C -> disp_valid=1 and disp_data=3C one cycle later; vram_we stays 0.
//  3. Full FIFO: 5 pushes in consecutive cycles with disp_req=1 -> first 4 accepted, cpu_ready=0 after the 4th, the 5th is dropped; wr_pending=4.
//  4. Starvation (STARVE_LIMIT=64): FIFO holds 1 entry, disp_req=1 continuously -> the write is issued on the 65th cycle.
//     disp_valid=0 the following cycle; steal_cnt=1.
//  5. Ordering: push A,B,C to the same address with disp_req=0 -> VRAM ends with C; write sequence observed as A,B,C.
//  6. Async reset mid-drain, with 3 entries pending -> wr_pending=0, vram_we=0 immediately; cpu_ready=1, disp_valid=0 after release.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared grant encodings and default sizing for the VRAM arbiter
package vram_arbiter_pkg;
    localparam int DEF_ADDR_W       = 16;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int DEF_STARVE_LIMIT = 64;
    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_DISP  = 2'd1,
        GNT_WRITE = 2'd2,
        GNT_STEAL = 2'd3
    } gnt_e;
    function automatic logic is_pop(gnt_e g);
        return g == GNT_WRITE || g == GNT_STEAL;
    endfunction
endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: CPU write port, display read port and VRAM port of the arbiter
interface vram_arbiter_if import vram_arbiter_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = $clog2(DEF_FIFO_DEPTH) + 1
);
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_ready;
    logic [CNT_W-1:0]  wr_pending;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;
    logic [ADDR_W-1:0] vram_addr;
    logic              vram_we;
    logic [DATA_W-1:0] vram_din;
    logic [DATA_W-1:0] vram_dout;
    logic [15:0]       steal_cnt;
    modport slave (
        input  cpu_we, cpu_addr, cpu_data, disp_req, disp_addr, vram_dout,
        output cpu_ready, wr_pending, disp_valid, disp_data, vram_addr, vram_we, vram_din, steal_cnt
    );
    modport master (
        output cpu_we, cpu_addr, cpu_data, disp_req, disp_addr, vram_dout,
        input  cpu_ready, wr_pending, disp_valid, disp_data, vram_addr, vram_we, vram_din, steal_cnt
    );
endinterface

// File: rtl/vram_arbiter_wr_fifo.sv
// vram_arbiter_wr_fifo: CPU write queue; full is registered state so a same-cycle pop never admits a push
module vram_arbiter_wr_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 24,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rptr_q];
    assign count_o = cnt_q;

    // pointer and occupancy next state; pointers wrap naturally at power-of-2 depth
    always_comb begin
        wptr_d = push_ok ? wptr_q + PW'(1) : wptr_q;
        rptr_d = pop_ok ? rptr_q + PW'(1) : rptr_q;
        cnt_d  = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end

    // pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // entry storage; contents are meaningless once the pointers reset
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= din_i;
    end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares single-port VRAM between display reads (priority) and queued CPU writes
module vram_arbiter import vram_arbiter_pkg::*; #(
    parameter  int ADDR_W       = DEF_ADDR_W,
    parameter  int DATA_W       = DEF_DATA_W,
    parameter  int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter  int STARVE_LIMIT = DEF_STARVE_LIMIT,
    localparam int SW           = $clog2(STARVE_LIMIT + 1)
) (
    input logic         clk,
    input logic         rst,
    vram_arbiter_if.slave bus
);
    gnt_e                     gnt;
    logic                     pop, empty, full;
    logic [ADDR_W+DATA_W-1:0] head;
    logic [SW-1:0]            starve_q, starve_d;
    logic [15:0]              steal_q, steal_d;
    logic                     rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]        hold_q, hold_d;

    vram_arbiter_wr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ADDR_W + DATA_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.cpu_we),
        .pop_i   (pop),
        .din_i   ({bus.cpu_addr, bus.cpu_data}),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (bus.wr_pending)
    );

    // grant selection: steal beats display, display beats normal drain
    always_comb begin
        gnt = (!empty && starve_q == SW'(STARVE_LIMIT)) ? GNT_STEAL :
              bus.disp_req                              ? GNT_DISP  :
              !empty                                    ? GNT_WRITE : GNT_IDLE;
        pop = is_pop(gnt);
    end

    // VRAM port and status outputs; held quiet while reset is asserted
    always_comb begin
        bus.vram_we    = ~rst & pop;
        bus.vram_addr  = rst ? '0 : pop ? head[ADDR_W+DATA_W-1:DATA_W] : bus.disp_addr;
        bus.vram_din   = rst ? '0 : pop ? head[DATA_W-1:0] : '0;
        bus.cpu_ready  = ~full;
        bus.disp_valid = rd_valid_q;
        bus.disp_data  = rd_valid_q ? bus.vram_dout : hold_q;
        bus.steal_cnt  = steal_q;
    end

    // starve counter, steal counter and read-valid pipeline next state
    always_comb begin
        starve_d   = (pop || empty) ? '0 : gnt == GNT_DISP ? starve_q + SW'(1) : starve_q;
        steal_d    = (gnt == GNT_STEAL && bus.disp_req && steal_q != 16'hFFFF) ? steal_q + 16'd1 : steal_q;
        rd_valid_d = gnt == GNT_DISP;
        hold_d     = rd_valid_q ? bus.vram_dout : hold_q;
    end

    // arbiter state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q   <= '0;
            steal_q    <= '0;
            rd_valid_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            starve_q   <= starve_d;
            steal_q    <= steal_d;
            rd_valid_q <= rd_valid_d;
            hold_q     <= hold_d;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of grant priority, FIFO behaviour, starvation steal and reset
module tb_vram_arbiter;
    import vram_arbiter_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   we_seen;
    logic [7:0] ram [65536];

    vram_arbiter_if bus ();
    vram_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // synchronous single-port VRAM model, read-before-write
    always @(posedge clk) begin
        if (bus.vram_we) ram[bus.vram_addr] <= bus.vram_din;
        bus.vram_dout <= ram[bus.vram_addr];
    end

    initial ram[16'h0123] = 8'h3C;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu(input logic we, input logic [15:0] addr, input logic [7:0] data);
        bus.cpu_we   = we;
        bus.cpu_addr = addr;
        bus.cpu_data = data;
    endtask

    initial begin
        cpu(1'b0, 16'h0, 8'h0);
        bus.disp_req  = 1'b1;
        bus.disp_addr = 16'h5555;
        #1 rst = 1'b1;
        #2;
        check("rst_we", 32'(bus.vram_we), 32'h0);
        check("rst_addr", 32'(bus.vram_addr), 32'h0);
        check("rst_din", 32'(bus.vram_din), 32'h0);
        check("rst_ready", 32'(bus.cpu_ready), 32'h1);
        check("rst_pending", 32'(bus.wr_pending), 32'h0);
        check("rst_valid", 32'(bus.disp_valid), 32'h0);
        check("rst_data", 32'(bus.disp_data), 32'h0);
        check("rst_steal", 32'(bus.steal_cnt), 32'h0);
        @(posedge clk);
        #3;
        bus.disp_req = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        tick;

        // idle write
        cpu(1'b1, 16'h0010, 8'hA5);
        #1;
        check("t1_ready", 32'(bus.cpu_ready), 32'h1);
        check("t1_no_bypass", 32'(bus.vram_we), 32'h0);
        tick;
        cpu(1'b0, 16'h0, 8'h0);
        #1;
        check("t1_pending1", 32'(bus.wr_pending), 32'h1);
        check("t1_we", 32'(bus.vram_we), 32'h1);
        check("t1_addr", 32'(bus.vram_addr), 32'h0010);
        check("t1_din", 32'(bus.vram_din), 32'hA5);
        tick;
        check("t1_pending0", 32'(bus.wr_pending), 32'h0);
        check("t1_we_off", 32'(bus.vram_we), 32'h0);
        check("t1_ram", 32'(ram[16'h0010]), 32'hA5);

        // display read
        bus.disp_req  = 1'b1;
        bus.disp_addr = 16'h0123;
        #1;
        check("t2_addr", 32'(bus.vram_addr), 32'h0123);
        check("t2_we", 32'(bus.vram_we), 32'h0);
        tick;
        bus.disp_req = 1'b0;
        #1;
        check("t2_valid", 32'(bus.disp_valid), 32'h1);
        check("t2_data", 32'(bus.disp_data), 32'h3C);
        tick;
        check("t2_valid_off", 32'(bus.disp_valid), 32'h0);
        check("t2_hold", 32'(bus.disp_data), 32'h3C);

        // full FIFO under continuous display reads
        bus.disp_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cpu(1'b1, 16'h0100 + 16'(i), 8'h10 + 8'(i));
            #1;
            check("t3_ready", 32'(bus.cpu_ready), 32'(i < 4));
            check("t3_we", 32'(bus.vram_we), 32'h0);
            tick;
        end
        cpu(1'b0, 16'h0, 8'h0);
        #1;
        check("t3_pending", 32'(bus.wr_pending), 32'h4);
        check("t3_full", 32'(bus.cpu_ready), 32'h0);
        bus.disp_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t3_drain_we", 32'(bus.vram_we), 32'h1);
            check("t3_drain_addr", 32'(bus.vram_addr), 32'h0100 + 32'(i));
            check("t3_drain_din", 32'(bus.vram_din), 32'h10 + 32'(i));
            tick;
        end
        check("t3_empty", 32'(bus.wr_pending), 32'h0);
        check("t3_dropped", 32'(bus.vram_we), 32'h0);

        // starvation steal
        bus.disp_req  = 1'b1;
        bus.disp_addr = 16'h0200;
        cpu(1'b1, 16'h0300, 8'h77);
        tick;
        cpu(1'b0, 16'h0, 8'h0);
        we_seen = 0;
        for (int k = 1; k <= 64; k++) begin
            #1;
            if (bus.vram_we) we_seen++;
            tick;
        end
        check("t4_no_early", 32'(we_seen), 32'h0);
        check("t4_we", 32'(bus.vram_we), 32'h1);
        check("t4_addr", 32'(bus.vram_addr), 32'h0300);
        check("t4_din", 32'(bus.vram_din), 32'h77);
        check("t4_valid_before", 32'(bus.disp_valid), 32'h1);
        tick;
        check("t4_valid_after", 32'(bus.disp_valid), 32'h0);
        check("t4_steal", 32'(bus.steal_cnt), 32'h1);
        check("t4_pending", 32'(bus.wr_pending), 32'h0);

        // ordering to one address
        bus.disp_req = 1'b0;
        cpu(1'b1, 16'h0400, 8'h11);
        #1;
        check("t5_idle", 32'(bus.vram_we), 32'h0);
        tick;
        cpu(1'b1, 16'h0400, 8'h22);
        #1;
        check("t5_a", 32'(bus.vram_din), 32'h11);
        tick;
        cpu(1'b1, 16'h0400, 8'h33);
        #1;
        check("t5_b", 32'(bus.vram_din), 32'h22);
        check("t5_pending", 32'(bus.wr_pending), 32'h1);
        tick;
        cpu(1'b0, 16'h0, 8'h0);
        #1;
        check("t5_c", 32'(bus.vram_din), 32'h33);
        check("t5_c_addr", 32'(bus.vram_addr), 32'h0400);
        tick;
        check("t5_ram", 32'(ram[16'h0400]), 32'h33);

        // async reset mid-drain
        bus.disp_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu(1'b1, 16'h0500 + 16'(i), 8'hE0 + 8'(i));
            tick;
        end
        cpu(1'b0, 16'h0, 8'h0);
        bus.disp_req = 1'b0;
        #1;
        check("t6_pending3", 32'(bus.wr_pending), 32'h3);
        check("t6_draining", 32'(bus.vram_we), 32'h1);
        check("t6_inflight", 32'(bus.disp_valid), 32'h1);
        rst = 1'b1;
        #1;
        check("t6_rst_pending", 32'(bus.wr_pending), 32'h0);
        check("t6_rst_we", 32'(bus.vram_we), 32'h0);
        check("t6_rst_valid", 32'(bus.disp_valid), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        tick;
        check("t6_ready", 32'(bus.cpu_ready), 32'h1);
        check("t6_valid", 32'(bus.disp_valid), 32'h0);
        check("t6_we", 32'(bus.vram_we), 32'h0);
        check("t6_pending", 32'(bus.wr_pending), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
